// File: rtl/config_loader_pkg.sv
// Shared definitions for the configuration loader slice.
//   SYNC_BYTE  : frame delimiter searched for in the serial stream
//   WORD_WIDTH : default tile configuration word width
//   CKS_WIDTH  : width of the trailing frame checksum
//   state_t    : loader state enumeration
//   idx_width  : index width helper that never returns zero
package config_pkg;

    localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
    localparam int unsigned WORD_WIDTH = 16;
    localparam int unsigned CKS_WIDTH  = 8;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LOAD,
        CHECKSUM,
        COMMIT,
        ERROR
    } state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/config_loader_if.sv
// Serial-in / broadcast-out bus of the configuration loader.
//   start, bit_in, bit_valid         : frame source -> loader
//   bit_ready                        : loader accepts bit_in this cycle
//   config_data, config_enable       : word broadcast and one-hot tile strobe
//   busy, done, error                : loader status
// master = frame source / tile side, slave = loader.
interface config_loader_if #(
    parameter int unsigned NUM_TILES  = 4,
    parameter int unsigned WORD_WIDTH = 16
);

    logic                  start;
    logic                  bit_in;
    logic                  bit_valid;
    logic                  bit_ready;
    logic [WORD_WIDTH-1:0] config_data;
    logic [NUM_TILES-1:0]  config_enable;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        output start, bit_in, bit_valid,
        input  bit_ready, config_data, config_enable, busy, done, error
    );

    modport slave (
        input  start, bit_in, bit_valid,
        output bit_ready, config_data, config_enable, busy, done, error
    );

endinterface

// File: rtl/xor_checksum_acc.sv
// Assembles payload bits (MSB first) into bytes and XORs each completed
// byte into a running checksum.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart assembly and zero the checksum
//   bit_en   : bit_in is a payload bit this cycle
//   bit_in   : serial payload bit
//   checksum : XOR of all completed bytes since the last clear
module xor_checksum_acc
    import config_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 bit_en,
    input  logic                 bit_in,
    output logic [CKS_WIDTH-1:0] checksum
);

    logic [CKS_WIDTH-2:0] byte_sr;
    logic [2:0]           bit_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_sr  <= '0;
            bit_cnt  <= '0;
            checksum <= '0;
        end else if (clear) begin
            byte_sr  <= '0;
            bit_cnt  <= '0;
            checksum <= '0;
        end else if (bit_en) begin
            byte_sr <= {byte_sr[CKS_WIDTH-3:0], bit_in};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
                checksum <= checksum ^ {byte_sr, bit_in};
            end
        end
    end

endmodule

// File: rtl/config_loader.sv
// Serial configuration loader. Hunts for the sync byte, shifts in NUM_TILES
// payload words MSB first, checks the trailing XOR checksum and, only on a
// match, broadcasts the buffered words to the tiles one per cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : config_loader_if slave (serial input, broadcast output, status)
module config_loader #(
    parameter int unsigned NUM_TILES  = 4,
    parameter int unsigned WORD_WIDTH = config_pkg::WORD_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    config_loader_if.slave  bus
);

    import config_pkg::*;

    localparam int unsigned      IDX_W        = idx_width(NUM_TILES);
    localparam int unsigned      CNT_W        = idx_width(WORD_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_TILES - 1);
    localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(WORD_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_CKS_BIT = CNT_W'(CKS_WIDTH - 1);

    state_t                 state;
    state_t                 state_next;

    logic [7:0]             window;
    logic [WORD_WIDTH-2:0]  word_sr;
    logic [CNT_W-1:0]       bit_cnt;
    logic [IDX_W-1:0]       word_idx;
    logic [IDX_W-1:0]       commit_idx;
    logic [WORD_WIDTH-1:0]  buffer [NUM_TILES];
    logic                   done_r;
    logic                   error_r;
    logic [CKS_WIDTH-1:0]   checksum_acc;

    logic                   ready;
    logic                   xfer;
    logic [7:0]             window_shift;
    logic [WORD_WIDTH-1:0]  word_full;

    logic                   busy_c;
    logic [NUM_TILES-1:0]   enable_c;
    logic [WORD_WIDTH-1:0]  data_c;
    logic                   start_take;
    logic                   acc_en;
    logic                   word_store;
    logic                   cks_fail;

    assign ready        = (state == SYNC) || (state == LOAD) || (state == CHECKSUM);
    assign xfer         = bus.bit_valid && ready;
    assign window_shift = {window[6:0], bus.bit_in};
    assign word_full    = {word_sr, bus.bit_in};

    xor_checksum_acc u_cks (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_take),
        .bit_en   (acc_en),
        .bit_in   (bus.bit_in),
        .checksum (checksum_acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_c     = 1'b1;
        enable_c   = '0;
        data_c     = '0;
        start_take = 1'b0;
        acc_en     = 1'b0;
        word_store = 1'b0;
        cks_fail   = 1'b0;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.start) begin
                    start_take = 1'b1;
                    state_next = SYNC;
                end
            end
            SYNC: begin
                if (xfer && (window_shift == SYNC_BYTE)) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (xfer) begin
                    acc_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        word_store = 1'b1;
                        if (word_idx == LAST_IDX) begin
                            state_next = CHECKSUM;
                        end
                    end
                end
            end
            CHECKSUM: begin
                // The last payload byte landed in the accumulator at least
                // eight accepted bits ago, so checksum_acc is final here.
                if (xfer && (bit_cnt == LAST_CKS_BIT)) begin
                    if (window_shift == checksum_acc) begin
                        state_next = COMMIT;
                    end else begin
                        state_next = ERROR;
                        cks_fail   = 1'b1;
                    end
                end
            end
            COMMIT: begin
                enable_c = NUM_TILES'(1) << commit_idx;
                data_c   = buffer[commit_idx];
                if (commit_idx == LAST_IDX) begin
                    state_next = IDLE;
                end
            end
            ERROR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window     <= '0;
            word_sr    <= '0;
            bit_cnt    <= '0;
            word_idx   <= '0;
            commit_idx <= '0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            done_r <= (state == COMMIT) && (commit_idx == LAST_IDX);
            if (start_take) begin
                window     <= '0;
                bit_cnt    <= '0;
                word_idx   <= '0;
                commit_idx <= '0;
                error_r    <= 1'b0;
            end
            if (cks_fail) begin
                error_r <= 1'b1;
            end
            case (state)
                SYNC: begin
                    if (xfer) begin
                        window <= window_shift;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        word_sr <= word_full[WORD_WIDTH-2:0];
                        if (word_store) begin
                            bit_cnt  <= '0;
                            word_idx <= word_idx + IDX_W'(1);
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                CHECKSUM: begin
                    // The window is reused to collect the received checksum.
                    if (xfer) begin
                        window  <= window_shift;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                COMMIT: begin
                    commit_idx <= (commit_idx == LAST_IDX) ? '0 : commit_idx + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Buffer contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (word_store) begin
            buffer[word_idx] <= word_full;
        end
    end

    assign bus.bit_ready     = ready;
    assign bus.config_enable = enable_c;
    assign bus.config_data   = data_c;
    assign bus.busy          = busy_c;
    assign bus.done          = done_r;
    assign bus.error         = error_r;

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
- REQ-001: Parameter NUM_TILES, default 4, number of downstream switch boxes loaded per frame.
- REQ-002: Parameter WORD_WIDTH, default 16, bits per tile configuration word; SHALL equal the switch box config_data width.
- REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-004: rst  input  1  asynchronous, active-high reset.
- REQ-005: start  input  1  one-cycle request to begin receiving a frame.
- REQ-006: bit_in  input  1  serial configuration bit.
- REQ-007: bit_valid  input  1  bit_in is valid this cycle.
- REQ-008: bit_ready  output  1  loader accepts bit_in this cycle; a bit transfers only when bit_valid and bit_ready are both high.
- REQ-009: config_data  output  WORD_WIDTH  word broadcast to all tiles.
- REQ-010: config_enable  output  NUM_TILES  one-hot per-tile load strobe.
- REQ-011: busy  output  1  high in every state except IDLE.
- REQ-012: done  output  1  one-cycle pulse on successful commit.
- REQ-013: error  output  1  sticky checksum failure flag.

Function
- REQ-014: Frame, serial MSB-first: sync byte 0xA5, then NUM_TILES payload words (word 0 first), then an 8-bit checksum.
- REQ-015: Checksum SHALL equal the XOR of all 2*NUM_TILES payload bytes; the sync byte is excluded.
- REQ-016: States SHALL be IDLE, SYNC, LOAD, CHECKSUM, COMMIT, ERROR.
- REQ-017: IDLE -> SYNC on start; start while busy SHALL be ignored.
- REQ-018: SYNC: transferred bits shift into an 8-bit window; -> LOAD on the edge where the window equals 0xA5; no bit limit; non-matching bits are discarded.
- REQ-019: LOAD: bits fill the current word; after WORD_WIDTH bits the word is stored to buffer[index] and index increments; after word NUM_TILES-1 -> CHECKSUM.
- REQ-020: CHECKSUM: after 8 bits, compare against the running XOR; match -> COMMIT, mismatch -> ERROR; the transition occurs on the edge accepting the final checksum bit.
- REQ-021: bit_ready SHALL be high in SYNC, LOAD, CHECKSUM, and low otherwise; bit_valid while bit_ready is low SHALL be ignored.
- REQ-022: COMMIT lasts exactly NUM_TILES cycles; in cycle k, config_enable = 1<<k and config_data = buffer[k]; bit k=0 is asserted in the cycle immediately after the final checksum bit is accepted.
- REQ-023: done SHALL pulse in the cycle after config_enable[NUM_TILES-1]; state returns to IDLE in that same cycle.
- REQ-024: Outside COMMIT, config_enable = 0 and config_data = 0.
- REQ-025: ERROR: no enables are issued and error = 1; -> IDLE the next cycle; error stays high until the next accepted start or rst.
- REQ-026: A failed frame SHALL NOT alter any tile; the buffer is committed only after a checksum match.
- REQ-027: Bit stalls (bit_valid low) of any length SHALL be tolerated in SYNC, LOAD and CHECKSUM without loss of state.

Reset
- REQ-028: rst high SHALL immediately force: state = IDLE, bit_ready = 0, config_enable = 0, config_data = 0, busy = 0, done = 0, error = 0, counters and checksum = 0.
- REQ-029: rst asserted mid-frame or mid-COMMIT SHALL abort the operation; remaining enables SHALL NOT issue; buffer contents are don't-care.

Structure
- REQ-030: Shared package config_pkg SHALL hold SYNC_BYTE = 8'hA5, WORD_WIDTH = 16, and the state enumeration type.
- REQ-031: Sub-module xor_checksum_acc (byte assembler plus XOR accumulator with clear) SHALL compute the running checksum; all other logic stays in config_loader.

Verification (NUM_TILES = 2)
- REQ-032: Frame A5, 1234, ABCD, checksum 40 sent with continuous valid -> config_enable 01/data 1234 then 10/ABCD on consecutive cycles; done pulses next cycle; error = 0.
- REQ-033: Same frame with checksum 41 -> no config_enable ever asserted; error = 1 until the next start.
- REQ-034: Garbage bits 0110 followed by the REQ-032 frame -> sync found, identical commit as REQ-032.
- REQ-035: REQ-032 frame with bit_valid toggling randomly at 50% -> identical commit values; bits offered while bit_ready = 0 are dropped.
- REQ-036: rst pulsed after the first word, then a clean frame 5555/AAAA with checksum 00 -> only 5555/AAAA are committed; no 1234 appears.
- REQ-037: start pulsed during LOAD -> ignored; frame completes normally.
